// File: rtl/hw_fpga_top_uart_regs.sv
// UART register-access debug port: 10-byte 5B..A4 frames read/write 32-bit registers.
// Define DEBUG_SCRATCHPAD_EN to map a read/write scratchpad at index 0x03.
module hw_fpga_top_uart_regs #(
    parameter int unsigned CLK_FREQ_HZ    = 100000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter logic [31:0] FPGA_VERSION   = 32'h0001_0000,
    parameter logic [31:0] FPGA_ID        = 32'h4844_5746,
    parameter logic [31:0] BUILD_DATE     = 32'h2025_0101,
    parameter int unsigned HEARTBEAT_CLKS = CLK_FREQ_HZ / 2
) (
    input  logic HDW_FPGA_100M_CLK,
    input  logic HDW_DEVRST_N,
    input  logic HDW_DBUG_SCLK,
    output logic HDW_DBUG_HEADER2,
    output logic HDW_FPGA_DONE,
    output logic HDW_FPGA_STAT_LED1,
    output logic HDW_FPGA_STAT_LED2
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMO_CLKS     = 16 * CLKS_PER_BIT;
    localparam int unsigned TMO_W        = $clog2(TMO_CLKS);
    localparam int unsigned HB_W         = $clog2(HEARTBEAT_CLKS);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic clk, rst_n;
    assign clk   = HDW_FPGA_100M_CLK;
    assign rst_n = HDW_DEVRST_N;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StHunt, StCollect, StCheck, StExec, StRespond} p_state_e;

    rx_state_e rx_state_q, rx_state_d;
    logic rxd_meta, rxd_sync, rxd_prev;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;

    logic [9:0] tx_shift_q, tx_shift_d;
    logic [3:0] tx_left_q, tx_left_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic txd_q, tx_idle, tx_ready, tx_start;
    logic [7:0] tx_byte;

    p_state_e p_state_q, p_state_d;
    logic [2:0] byte_cnt_q, byte_cnt_d;
    logic [63:0] frame_q, frame_d;
    logic [3:0] resp_idx_q, resp_idx_d;
    logic [31:0] rdata_q, rdata_d, reg_rdata;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic led2_q, led2_d, led1_q, done_q;
    logic [HB_W-1:0] hb_cnt_q;
`ifdef DEBUG_SCRATCHPAD_EN
    logic [31:0] scratch_q;
    logic scratch_we;
`endif

    // Receiver: start bit re-checked mid-bit, data and stop sampled at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rxd_prev && !rxd_sync) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HALF_BIT) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == FULL_BIT) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == FULL_BIT) begin
                    rx_state_d = RxIdle;
                    rx_valid_d = rxd_sync;
                    rx_err_d   = !rxd_sync;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Loading on the last stop-bit clock gives back-to-back bytes with no gap.
    assign tx_idle  = (tx_left_q == 4'd0);
    assign tx_ready = tx_idle || (tx_left_q == 4'd1 && tx_cnt_q == FULL_BIT);

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_left_d  = tx_left_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_start) begin
            tx_shift_d = {1'b1, tx_byte, 1'b0};
            tx_left_d  = 4'd10;
            tx_cnt_d   = '0;
        end else if (!tx_idle) begin
            if (tx_cnt_q == FULL_BIT) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_left_d  = tx_left_q - 4'd1;
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        unique case (frame_q[39:32])
            8'h00:   reg_rdata = FPGA_VERSION;
            8'h01:   reg_rdata = FPGA_ID;
            8'h02:   reg_rdata = BUILD_DATE;
`ifdef DEBUG_SCRATCHPAD_EN
            8'h03:   reg_rdata = scratch_q;
`endif
            default: reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        unique case (resp_idx_q)
            4'd0:    tx_byte = 8'h5B;
            4'd1:    tx_byte = frame_q[63:56];
            4'd2:    tx_byte = frame_q[55:48];
            4'd3:    tx_byte = frame_q[47:40];
            4'd4:    tx_byte = frame_q[39:32];
            4'd5:    tx_byte = rdata_q[31:24];
            4'd6:    tx_byte = rdata_q[23:16];
            4'd7:    tx_byte = rdata_q[15:8];
            4'd8:    tx_byte = rdata_q[7:0];
            default: tx_byte = 8'hA4;
        endcase
    end

    always_comb begin
        p_state_d  = p_state_q;
        byte_cnt_d = byte_cnt_q;
        frame_d    = frame_q;
        resp_idx_d = resp_idx_q;
        rdata_d    = rdata_q;
        tmo_d      = '0;
        led2_d     = led2_q;
        tx_start   = 1'b0;
`ifdef DEBUG_SCRATCHPAD_EN
        scratch_we = 1'b0;
`endif
        unique case (p_state_q)
            StHunt: begin
                byte_cnt_d = '0;
                if (rx_valid_q && rx_shift_q == 8'h5B) p_state_d = StCollect;
            end
            StCollect, StCheck: begin
                if (rx_err_q) begin
                    p_state_d = StHunt;
                end else if (rx_valid_q) begin
                    if (p_state_q == StCheck) begin
                        p_state_d = (rx_shift_q == 8'hA4) ? StExec : StHunt;
                    end else begin
                        frame_d    = {frame_q[55:0], rx_shift_q};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 3'd7) p_state_d = StCheck;
                    end
                end else if (tmo_q == TMO_W'(TMO_CLKS - 1)) begin
                    p_state_d = StHunt;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StExec: begin
`ifdef DEBUG_SCRATCHPAD_EN
                scratch_we = frame_q[63] && (frame_q[39:32] == 8'h03);
`endif
                led2_d     = !led2_q;
                resp_idx_d = '0;
                p_state_d  = StRespond;
            end
            StRespond: begin
                // First cycle here sees the register after the EXEC write.
                if (resp_idx_q == 4'd0) rdata_d = reg_rdata;
                if (resp_idx_q == 4'd10) begin
                    if (tx_idle) p_state_d = StHunt;
                end else if (tx_ready) begin
                    tx_start   = 1'b1;
                    resp_idx_d = resp_idx_q + 4'd1;
                end
            end
            default: p_state_d = StHunt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rxd_prev   <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_shift_q <= '1;
            tx_left_q  <= '0;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
            p_state_q  <= StHunt;
            byte_cnt_q <= '0;
            frame_q    <= '0;
            resp_idx_q <= '0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            led2_q     <= 1'b0;
        end else begin
            rxd_meta   <= HDW_DBUG_SCLK;
            rxd_sync   <= rxd_meta;
            rxd_prev   <= rxd_sync;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_shift_q <= tx_shift_d;
            tx_left_q  <= tx_left_d;
            tx_cnt_q   <= tx_cnt_d;
            txd_q      <= (tx_left_d == 4'd0) ? 1'b1 : tx_shift_d[0];
            p_state_q  <= p_state_d;
            byte_cnt_q <= byte_cnt_d;
            frame_q    <= frame_d;
            resp_idx_q <= resp_idx_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            led2_q     <= led2_d;
        end
    end

`ifdef DEBUG_SCRATCHPAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scratch_q <= '0;
        else if (scratch_we) scratch_q <= frame_q[31:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            led1_q   <= 1'b0;
            hb_cnt_q <= '0;
        end else begin
            done_q <= 1'b1;
            if (hb_cnt_q == HB_W'(HEARTBEAT_CLKS - 1)) begin
                hb_cnt_q <= '0;
                led1_q   <= !led1_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + 1'b1;
            end
        end
    end

    assign HDW_DBUG_HEADER2   = txd_q;
    assign HDW_FPGA_DONE      = done_q;
    assign HDW_FPGA_STAT_LED1 = led1_q;
    assign HDW_FPGA_STAT_LED2 = led2_q;
endmodule

// File: tb/tb_hw_fpga_top_uart_regs.sv
// Directed bench for hw_fpga_top_uart_regs: frames in on RXD, replies decoded from TXD.
`timescale 1ns/1ps
module tb_hw_fpga_top_uart_regs;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic txd, done, led1, led2;

    int checks = 0;
    int failures = 0;
    int tx_edges = 0;
    int stop_errs = 0;
    logic [7:0] tx_bytes[$];
    logic exp_led2 = 1'b0;
    logic [31:0] scratch_exp;

    hw_fpga_top_uart_regs #(
        .CLK_FREQ_HZ   (1600000),
        .BAUD_RATE     (100000),
        .HEARTBEAT_CLKS(1000)
    ) dut (
        .HDW_FPGA_100M_CLK (clk),
        .HDW_DEVRST_N      (rst_n),
        .HDW_DBUG_SCLK     (rxd),
        .HDW_DBUG_HEADER2  (txd),
        .HDW_FPGA_DONE     (done),
        .HDW_FPGA_STAT_LED1(led1),
        .HDW_FPGA_STAT_LED2(led2)
    );

    always #5 clk = ~clk;

    // TX decoder: samples at bit centres on the falling clock edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            tx_edges++;
            repeat (CPB / 2) @(negedge clk);
            if (txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) stop_errs++;
                tx_bytes.push_back(b);
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [79:0] f);
        for (int i = 0; i < 10; i++) send_byte(f[79 - 8 * i -: 8]);
    endtask

    task automatic expect_reply(input string tag, input logic [79:0] exp);
        int c = 0;
        logic [7:0] b;
        while (tx_bytes.size() < 10 && c < 200 * CPB) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_count"}, 32'(tx_bytes.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (tx_bytes.size() > 0) begin
                b = tx_bytes.pop_front();
                check($sformatf("%s_b%0d", tag, i), {24'h0, b}, {24'h0, exp[79 - 8 * i -: 8]});
            end
        end
        repeat (4 * CPB) @(negedge clk);
    endtask

    initial begin
        int edges_before;
        repeat (5) @(negedge clk);
        check("rst_txd", {31'h0, txd}, 32'd1);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_led1", {31'h0, led1}, 32'd0);
        check("rst_led2", {31'h0, led2}, 32'd0);
        repeat (10000) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("done_up", {31'h0, done}, 32'd1);
        check("led1_early", {31'h0, led1}, 32'd0);
        repeat (1498) @(negedge clk);
        check("led1_toggled", {31'h0, led1}, 32'd1);

        send_frame(80'h5B_00000000_00000000_A4);
        expect_reply("rd0", 80'h5B_00000000_00010000_A4);
        exp_led2 = ~exp_led2;
        check("led2_rd0", {31'h0, led2}, {31'h0, exp_led2});

        send_frame(80'h5B_00000001_00000000_A4);
        expect_reply("rd1", 80'h5B_00000001_48445746_A4);
        send_frame(80'h5B_00000002_00000000_A4);
        expect_reply("rd2", 80'h5B_00000002_20250101_A4);
        exp_led2 = ~exp_led2 ^ 1'b1;

`ifdef DEBUG_SCRATCHPAD_EN
        scratch_exp = 32'h12345678;
`else
        scratch_exp = 32'h0;
`endif
        send_frame(80'h5B_80000003_12345678_A4);
        expect_reply("wr3", {8'h5B, 32'h80000003, scratch_exp, 8'hA4});
        send_frame(80'h5B_00000003_00000000_A4);
        expect_reply("rd3", {8'h5B, 32'h00000003, scratch_exp, 8'hA4});
        check("led2_after4", {31'h0, led2}, {31'h0, exp_led2});

        edges_before = tx_edges;
        send_frame(80'h5B_00000000_00000000_A5);
        repeat (20 * CPB) @(negedge clk);
        check("bad_trl_tx", 32'(tx_edges), 32'(edges_before));
        check("bad_trl_led2", {31'h0, led2}, {31'h0, exp_led2});
        send_frame(80'h5B_00000000_00000000_A4);
        expect_reply("rd0_after_bad", 80'h5B_00000000_00010000_A4);
        exp_led2 = ~exp_led2;

        // Glitch shorter than half a bit must not start a byte.
        @(negedge clk) rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(80'h5B_00000001_00000000_A4);
        expect_reply("rd1_after_glitch", 80'h5B_00000001_48445746_A4);
        exp_led2 = ~exp_led2;

        // Stalled frame must time out so the next 5B starts a fresh frame.
        send_byte(8'h5B);
        send_byte(8'h00);
        repeat (20 * CPB) @(negedge clk);
        send_frame(80'h5B_00000002_00000000_A4);
        expect_reply("rd2_after_tmo", 80'h5B_00000002_20250101_A4);
        exp_led2 = ~exp_led2;
        check("led2_after_tmo", {31'h0, led2}, {31'h0, exp_led2});

        for (int i = 0; i < 5; i++) send_byte(i == 0 ? 8'h5B : 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_txd", {31'h0, txd}, 32'd1);
        check("mid_rst_done", {31'h0, done}, 32'd0);
        check("mid_rst_led2", {31'h0, led2}, 32'd0);
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        exp_led2 = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_done_up", {31'h0, done}, 32'd1);
        send_frame(80'h5B_00000000_00000000_A4);
        expect_reply("rd0_after_rst", 80'h5B_00000000_00010000_A4);
        exp_led2 = ~exp_led2;
        check("after_rst_single", 32'(tx_bytes.size()), 32'd0);
        check("led2_after_rst", {31'h0, led2}, {31'h0, exp_led2});

        send_frame(80'h5B_80000000_FFFFFFFF_A4);
        expect_reply("wr_ro", 80'h5B_80000000_00010000_A4);
        send_frame(80'h5B_00000000_00000000_A4);
        expect_reply("rd0_after_wr", 80'h5B_00000000_00010000_A4);

        repeat (20 * CPB) @(negedge clk);
        check("stop_bits", 32'(stop_errs), 32'd0);
        check("no_extra_tx", 32'(tx_bytes.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
